serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle digit-serial unsigned subtractor; counterpart of the ripple-carry adder.
//   Computes diff = a - b (mod 2^DATA_WIDTH) and borrow-out bo.
//   Uses a + ~b + 1, DIGIT_WIDTH bits per cycle, LSB digit first.
//   Sits beside the adders in the GF/integer arithmetic datapath.
//   Valid/ready handshakes on both sides, so it drops into a pipelined operand stream.
// PARAMETERS
//   DATA_WIDTH   32   operand/result width in bits
//   DIGIT_WIDTH  8    bits processed per cycle; must divide DATA_WIDTH (elaboration check)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous, active-high reset
//   in_valid   in   1           operands a/b valid
//   in_ready   out  1           block can accept operands
//   a          in   DATA_WIDTH  minuend, unsigned
//   b          in   DATA_WIDTH  subtrahend, unsigned
//   out_valid  out  1           diff/bo valid
//   out_ready  in   1           consumer accepts result
//   diff       out  DATA_WIDTH  a - b modulo 2^DATA_WIDTH
//   bo         out  1           borrow out; 1 iff a < b (unsigned)
// BEHAVIOUR
//   - Clock and reset:
//     - One clock domain.
//     - rst asserted at any time (including mid-RUN or DONE) forces IDLE and clears everything.
//     - Reset values: in_ready=1 (after rst deasserts), out_valid=0, diff=0, bo=0.
//     - Internal regs cleared: digit counter, carry, operand shift registers.
//   - FSM IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: latch a into A_SR and ~b into B_SR.
//     - Set carry=1, cnt=0, then go to RUN.
//   - FSM RUN:
//     - in_ready=0.
//     - Each cycle: {c', d} = A_SR[DIGIT-1:0] + B_SR[DIGIT-1:0] + carry.
//     - Shift d into the result register from the MSB side, DIGIT_WIDTH bits per cycle.
//     - Shift A_SR and B_SR right by DIGIT_WIDTH; carry <= c'.
//     - Stays in RUN for exactly NUM_DIGITS = DATA_WIDTH/DIGIT_WIDTH cycles.
//     - On the last digit, go to DONE.
//   - FSM DONE:
//     - out_valid=1, diff=result register, bo = ~final carry.
//     - diff/bo stay stable while out_valid && !out_ready.
//     - On out_ready: go to IDLE (out_valid=0 next cycle).
//   - Latency and throughput:
//     - Operand accept at cycle T gives out_valid high at T+NUM_DIGITS+1.
//     - No overlap between operations: one result per NUM_DIGITS+2 cycles minimum.
//   - Handshake rules:
//     - in_ready is low in RUN and DONE; in_valid there is ignored.
//     - out_ready outside DONE has no effect.
//     - a/b are sampled only at accept, so later changes are harmless.
//   - Degenerate case: DIGIT_WIDTH==DATA_WIDTH gives a single RUN cycle; the rules above still hold.
//   - Arithmetic:
//     - Unsigned, modular.
//     - No overflow flag; signed users derive overflow externally.
// STRUCTURE
//   - Shared package gf_arith_pkg:
//     - FSM state encoding localparams ST_IDLE/ST_RUN/ST_DONE.
//     - NUM_DIGITS helper function and counter width ($clog2).
//   - Sub-module digit_subtractor (combinational):
//     - Operands DIGIT_WIDTH-wide, ci -> d, co.
//     - Internally a full-adder chain with b pre-inverted by the caller.
//   - Top level holds the FSM, digit counter, shift registers and the carry flop.
// TESTING
//   1. Reset: rst=1 mid-RUN (a=5, b=3, after 2 cycles) -> next cycle out_valid=0, in_ready=1, diff=0, bo=0;
//      a following op a=9, b=4 -> diff=5, bo=0.
//   2. Basic: a=32'h0000_0010, b=32'h0000_0003 -> diff=32'h0000_000D, bo=0;
//      out_valid rises exactly 5 cycles after accept (DIGIT_WIDTH=8).
//   3. Underflow: a=0, b=1 -> diff=32'hFFFF_FFFF, bo=1; a=b=32'hDEAD_BEEF -> diff=0, bo=0.
//   4. Cross-digit borrow: a=32'h0001_0000, b=32'h0000_0001 -> diff=32'h0000_FFFF, bo=0.
//   5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> diff/bo stable and in_ready=0;
//      in_valid pulses ignored; release -> IDLE, next op accepted.
//   6. Random: 10k random a/b, random in_valid/out_ready, DIGIT_WIDTH in {1,8,32}
//      -> diff==a-b, bo==(a<b) for every transaction, in order.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_e    : controller state encoding (IDLE / RUN / DONE)
//   num_digits : number of RUN cycles for a given operand/digit width
//   cnt_width  : digit counter width, never narrower than one bit
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int data_w, input int digit_w);
    return data_w / digit_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready  : operand handshake, a = minuend, b = subtrahend
//   out_valid/out_ready: result handshake, diff = a - b, bo = borrow out
//   master modport     : producer/consumer side, slave modport: subtractor side
interface serial_subtractor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  bo;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bo
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bo
  );
endinterface

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT_WIDTH-bit ripple adder slice used for one subtraction digit.
// The caller pre-inverts the subtrahend, so a_i + b_i + ci_i yields a - b digits.
//   a_i, b_i : digit operands
//   ci_i     : carry in (1 for the first digit)
//   d_o      : digit result
//   co_o     : carry out (inverted borrow)
module serial_subtractor_digit #(
  parameter int DIGIT_WIDTH = 8
) (
  input  logic [DIGIT_WIDTH-1:0] a_i,
  input  logic [DIGIT_WIDTH-1:0] b_i,
  input  logic                   ci_i,
  output logic [DIGIT_WIDTH-1:0] d_o,
  output logic                   co_o
);

  logic [DIGIT_WIDTH:0] c;

  always_comb begin
    c    = '0;
    d_o  = '0;
    c[0] = ci_i;
    for (int i = 0; i < DIGIT_WIDTH; i++) begin
      d_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    co_o = c[DIGIT_WIDTH];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b mod 2^DATA_WIDTH, bo = (a < b).
// Computes a + ~b + 1 one DIGIT_WIDTH slice per cycle, LSB digit first.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of serial_subtractor_if (operand and result handshakes)
//
// state   | meaning
// IDLE    | in_ready high, waiting for operands
// RUN     | one digit per cycle, NUM_DIGITS cycles
// DONE    | result presented, waiting for out_ready
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
  localparam int CNT_W      = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_width
    $error("serial_subtractor: DIGIT_WIDTH must divide DATA_WIDTH");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] a_sr_q, a_sr_d;
  logic [DATA_WIDTH-1:0] b_sr_q, b_sr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic [DIGIT_WIDTH-1:0] digit_d;
  logic                   digit_co;
  logic [DATA_WIDTH-1:0]  a_shift, b_shift, result_shift;

  serial_subtractor_digit #(
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_digit (
    .a_i  (a_sr_q[DIGIT_WIDTH-1:0]),
    .b_i  (b_sr_q[DIGIT_WIDTH-1:0]),
    .ci_i (carry_q),
    .d_o  (digit_d),
    .co_o (digit_co)
  );

  // New digits enter the result from the MSB side so that after the last
  // digit the LSB digit has reached bit 0.
  if (DIGIT_WIDTH == DATA_WIDTH) begin : g_single
    assign a_shift      = '0;
    assign b_shift      = '0;
    assign result_shift = digit_d;
  end else begin : g_multi
    assign a_shift      = {{DIGIT_WIDTH{1'b0}}, a_sr_q[DATA_WIDTH-1:DIGIT_WIDTH]};
    assign b_shift      = {{DIGIT_WIDTH{1'b0}}, b_sr_q[DATA_WIDTH-1:DIGIT_WIDTH]};
    assign result_shift = {digit_d, result_q[DATA_WIDTH-1:DIGIT_WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = ~bus.b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = result_shift;
        a_sr_d   = a_shift;
        b_sr_d   = b_shift;
        carry_d  = digit_co;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Final carry is the inverted borrow; outputs are forced to zero outside
  // DONE so the idle/reset view is clean.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.diff      = (state_q == ST_DONE) ? result_q : '0;
  assign bus.bo        = (state_q == ST_DONE) & ~carry_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if if8  ();
  serial_subtractor_if if1  ();
  serial_subtractor_if if32 ();

  serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_subtractor #(.DATA_WIDTH(32), .DIGIT_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation on the 8-bit-digit instance with out_ready held high.
  // Starts and ends on a negedge; lat counts cycles from accept to out_valid.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] d, output logic bo_v,
                       output int lat, output bit to);
    int n;
    to  = 1'b0;
    lat = 0;
    d   = '0;
    bo_v = 1'b0;
    n = 0;
    while (!if8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if8.in_ready) begin
      to = 1'b1;
      return;
    end
    if8.a = av;
    if8.b = bv;
    if8.in_valid  = 1'b1;
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    if8.a = $urandom;
    if8.b = $urandom;
    lat = 1;
    while (!if8.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!if8.out_valid) begin
      to = 1'b1;
      return;
    end
    d    = if8.diff;
    bo_v = if8.bo;
    @(negedge clk);
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic bo_v;
    int lat;
    bit to;
    checks++;
    if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.diff !== 32'h0 || if8.bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%h bo=%b, want 1 0 0 0",
               if8.in_ready, if8.out_valid, if8.diff, if8.bo);
    end
    if8.a = 32'd5;
    if8.b = 32'd3;
    if8.in_valid  = 1'b1;
    if8.out_ready = 1'b0;
    @(negedge clk);
    if8.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.diff !== 32'h0 || if8.bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: in_ready=%b out_valid=%b diff=%h bo=%b, want 1 0 0 0",
               if8.in_ready, if8.out_valid, if8.diff, if8.bo);
    end
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd9, 32'd4, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'd5 || bo_v !== 1'b0) begin
      errors++;
      $display("FAIL reset_next_op: timeout=%b diff=%h bo=%b, want diff=00000005 bo=0", to, d, bo_v);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic bo_v;
    int lat;
    bit to;
    do_op(32'h0000_0010, 32'h0000_0003, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'h0000_000D || bo_v !== 1'b0) begin
      errors++;
      $display("FAIL basic_value: timeout=%b diff=%h bo=%b, want diff=0000000d bo=0", to, d, bo_v);
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 5", lat);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    logic bo_v;
    int lat;
    bit to;
    do_op(32'h0, 32'h1, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'hFFFF_FFFF || bo_v !== 1'b1) begin
      errors++;
      $display("FAIL underflow_0_1: timeout=%b diff=%h bo=%b, want diff=ffffffff bo=1", to, d, bo_v);
    end
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'h0 || bo_v !== 1'b0) begin
      errors++;
      $display("FAIL equal_operands: timeout=%b diff=%h bo=%b, want diff=00000000 bo=0", to, d, bo_v);
    end
  endtask

  task automatic test_cross_borrow();
    logic [31:0] d;
    logic bo_v;
    int lat;
    bit to;
    do_op(32'h0001_0000, 32'h0000_0001, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'h0000_FFFF || bo_v !== 1'b0) begin
      errors++;
      $display("FAIL cross_borrow: timeout=%b diff=%h bo=%b, want diff=0000ffff bo=0", to, d, bo_v);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic bo_v;
    int lat;
    bit to;
    int n;
    logic [31:0] exp_d;
    logic exp_bo;
    exp_d  = 32'h1234_5678 - 32'h2000_0000;
    exp_bo = (32'h1234_5678 < 32'h2000_0000);
    if8.a = 32'h1234_5678;
    if8.b = 32'h2000_0000;
    if8.in_valid  = 1'b1;
    if8.out_ready = 1'b0;
    @(negedge clk);
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (if8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_timeout: out_valid=%b after %0d cycles, want 1", if8.out_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0 || if8.diff !== exp_d || if8.bo !== exp_bo) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b diff=%h bo=%b, want 1 0 %h %b",
                 i, if8.out_valid, if8.in_ready, if8.diff, if8.bo, exp_d, exp_bo);
      end
      if8.in_valid = i[0];
      if8.a = $urandom;
      if8.b = $urandom;
      @(negedge clk);
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    @(negedge clk);
    if8.out_ready = 1'b0;
    checks++;
    if (if8.out_valid !== 1'b0 || if8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", if8.out_valid, if8.in_ready);
    end
    do_op(32'd100, 32'd7, d, bo_v, lat, to);
    checks++;
    if (to || d !== 32'd93 || bo_v !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL backpressure_next_op: timeout=%b diff=%h bo=%b lat=%0d, want 0000005d 0 5",
               to, d, bo_v, lat);
    end
  endtask

  // Reference model: a FIFO of accepted operand pairs; each result is a-b and a<b.
  task automatic run_random(virtual serial_subtractor_if vif, input int n_ops,
                            input int nd, input string tag);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          qt[$];
    int          cyc;
    int          done;
    int          limit;
    bit          prev_valid;
    int          sel;
    logic [31:0] ra, rb;
    cyc = 0;
    done = 0;
    prev_valid = 1'b0;
    limit = n_ops * (nd + 2) * 4 + 1000;
    while (done < n_ops && cyc < limit) begin
      @(negedge clk);
      cyc++;
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = ra;
      else if (sel == 1) ra = 32'h0;
      else if (sel == 2) rb = 32'hFFFF_FFFF;
      else if (sel == 3) rb = {24'h0, rb[7:0]};
      vif.a = ra;
      vif.b = rb;
      vif.in_valid  = ($urandom_range(0, 3) != 0);
      vif.out_ready = ($urandom_range(0, 3) != 0);

      checks++;
      if (vif.in_ready !== (qa.size() == 0)) begin
        errors++;
        $display("FAIL %s in_ready: got %b with %0d pending, want %b", tag, vif.in_ready, qa.size(), qa.size() == 0);
      end
      if (vif.out_valid === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL %s spurious_out_valid: got 1 with no pending op, want 0", tag);
        end else begin
          if (!prev_valid && (cyc - qt[0]) !== nd + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, cyc - qt[0], nd + 1);
          end else if (vif.diff !== qa[0] - qb[0] || vif.bo !== (qa[0] < qb[0])) begin
            errors++;
            $display("FAIL %s result: a=%h b=%h got diff=%h bo=%b, want diff=%h bo=%b",
                     tag, qa[0], qb[0], vif.diff, vif.bo, qa[0] - qb[0], qa[0] < qb[0]);
          end
          if (vif.out_ready) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            void'(qt.pop_front());
            done++;
          end
        end
      end
      if (vif.in_valid && vif.in_ready) begin
        qa.push_back(ra);
        qb.push_back(rb);
        qt.push_back(cyc);
      end
      prev_valid = (vif.out_valid === 1'b1);
    end
    vif.in_valid = 1'b0;
    checks++;
    if (done !== n_ops) begin
      errors++;
      $display("FAIL %s random_timeout: got %0d results, want %0d", tag, done, n_ops);
    end
  endtask

  task automatic test_random();
    fork
      run_random(if1,  1200, 32, "dw1");
      run_random(if8,  3800, 4,  "dw8");
      run_random(if32, 5000, 1,  "dw32");
    join
    @(negedge clk);
    if1.out_ready  = 1'b0;
    if8.out_ready  = 1'b0;
    if32.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if8.in_valid  = 1'b0; if8.out_ready  = 1'b0; if8.a  = '0; if8.b  = '0;
    if1.in_valid  = 1'b0; if1.out_ready  = 1'b0; if1.a  = '0; if1.b  = '0;
    if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.a = '0; if32.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_underflow();
    test_cross_borrow();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
